// File: rtl/cache_wr_bridge_if.sv
// Cache-side write request and AXI4 write-channel signals for cache_wr_bridge.
// The bridge uses the master modport (it is the AXI master); the
// environment (cache request path plus AXI slave) uses the slave modport.
interface cache_wr_bridge_if;
    // Cache write request side
    logic         wr_req;
    logic [2:0]   wr_type;
    logic [31:0]  wr_addr;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;
    logic         wr_rdy;
    logic [31:0]  chk_addr;
    logic         chk_hit;
    logic         wr_err;
    // AXI4 write address channel
    logic [3:0]   awid;
    logic [31:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         awvalid;
    logic         awready;
    // AXI4 write data channel
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready;
    // AXI4 write response channel
    logic [3:0]   bid;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;

    modport master (
        input  wr_req, wr_type, wr_addr, wr_wstrb, wr_data, chk_addr,
        input  awready, wready, bid, bresp, bvalid,
        output wr_rdy, chk_hit, wr_err,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid, bready
    );

    modport slave (
        output wr_req, wr_type, wr_addr, wr_wstrb, wr_data, chk_addr,
        output awready, wready, bid, bresp, bvalid,
        input  wr_rdy, chk_hit, wr_err,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        input  wdata, wstrb, wlast, wvalid, bready
    );
endinterface

// File: rtl/cache_wr_bridge.sv
// Write-side bridge from the 2-way cache to AXI4. Takes one request at a
// time (a 128-bit dirty-line writeback as a 4-beat INCR burst, or a single
// uncached store) and runs it through AW, W and B in strict sequence. Also
// flags when a pending cache read hits the line still being written.
module cache_wr_bridge #(
    parameter logic [3:0] AXI_ID = 4'd1
) (
    input logic               clk,
    input logic               reset,
    cache_wr_bridge_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AW   = 2'd1,
        S_W    = 2'd2,
        S_B    = 2'd3
    } state_t;

    // Control state (reset)
    state_t       state_q, state_d;
    logic         awvalid_q, awvalid_d;
    logic         wvalid_q, wvalid_d;
    logic         bready_q, bready_d;
    logic [1:0]   cnt_q, cnt_d;

    // Latched request (not reset; only meaningful while busy)
    logic         line_q, line_d;
    logic [31:0]  addr_q, addr_d;
    logic [2:0]   size_q, size_d;
    logic [3:0]   strb_q, strb_d;
    logic [127:0] data_q, data_d;

    logic         wr_rdy;
    logic         accept;
    logic         wlast;
    logic         unused_ok;

    assign wr_rdy = (state_q == S_IDLE) && !reset;
    assign accept = bus.wr_req && wr_rdy;
    // Uncached stores are a single beat, so every beat is the last one.
    assign wlast  = wvalid_q && (!line_q || (cnt_q == 2'd3));

    // Next-state and next-latch computation for the AW -> W -> B sequence
    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        cnt_d     = cnt_q;
        line_d    = line_q;
        addr_d    = addr_q;
        size_d    = size_q;
        strb_d    = strb_q;
        data_d    = data_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_AW;
                    awvalid_d = 1'b1;
                    if (bus.wr_type == 3'b100) begin
                        line_d = 1'b1;
                        addr_d = {bus.wr_addr[31:4], 4'b0000};
                        size_d = 3'd2;
                        strb_d = 4'hF;
                        data_d = bus.wr_data;
                    end else begin
                        line_d = 1'b0;
                        addr_d = bus.wr_addr;
                        // Unknown encodings fall back to a word store.
                        if (bus.wr_type[2] || (bus.wr_type[1:0] == 2'b11)) begin
                            size_d = 3'd2;
                        end else begin
                            size_d = {1'b0, bus.wr_type[1:0]};
                        end
                        strb_d = bus.wr_wstrb;
                        data_d = {96'b0, bus.wr_data[31:0]};
                    end
                end
            end
            S_AW: begin
                if (bus.awready) begin
                    state_d   = S_W;
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b1;
                    cnt_d     = 2'd0;
                end
            end
            S_W: begin
                if (bus.wready) begin
                    cnt_d = cnt_q + 2'd1;
                    if (wlast) begin
                        state_d  = S_B;
                        wvalid_d = 1'b0;
                        bready_d = 1'b1;
                    end
                end
            end
            S_B: begin
                if (bus.bvalid) begin
                    state_d  = S_IDLE;
                    bready_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register: control flops reset, latched request fields free-running
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            cnt_q     <= 2'd0;
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            cnt_q     <= cnt_d;
        end
        line_q <= line_d;
        addr_q <= addr_d;
        size_q <= size_d;
        strb_q <= strb_d;
        data_q <= data_d;
    end

    assign bus.wr_rdy  = wr_rdy;
    assign bus.chk_hit = (state_q != S_IDLE) && (bus.chk_addr[31:4] == addr_q[31:4]);
    assign bus.wr_err  = bready_q && bus.bvalid && (bus.bresp != 2'b00);

    assign bus.awid    = AXI_ID;
    assign bus.awaddr  = addr_q;
    assign bus.awlen   = line_q ? 8'd3 : 8'd0;
    assign bus.awsize  = size_q;
    assign bus.awburst = 2'b01;
    assign bus.awvalid = awvalid_q;

    assign bus.wdata   = data_q[{cnt_q, 5'b00000} +: 32];
    assign bus.wstrb   = strb_q;
    assign bus.wlast   = wlast;
    assign bus.wvalid  = wvalid_q;

    assign bus.bready  = bready_q;

    // Response ID and the byte offset of chk_addr are intentionally ignored.
    assign unused_ok = ^{bus.bid, bus.chk_addr[3:0]};

endmodule

// File: tb/tb_cache_wr_bridge.sv
// Directed bench for cache_wr_bridge: a table of single transactions with
// all readies high, then hand-written sequences for backpressure, line
// conflict detection, error response and reset in the middle of a burst.
module tb_cache_wr_bridge;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cache_wr_bridge_if bus();

    cache_wr_bridge #(.AXI_ID(4'd1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [2:0]   typ;
        logic [31:0]  addr;
        logic [3:0]   strb;
        logic [127:0] data;
        logic [31:0]  e_awaddr;
        logic [7:0]   e_len;
        logic [2:0]   e_size;
        logic [3:0]   e_strb;
        int           e_beats;
        logic [127:0] e_beat;   // beat i expected in bits [32*i+31:32*i]
    } vec_t;

    vec_t vecs[7];

    function automatic vec_t mk(input logic [2:0] t, input logic [31:0] a,
                                input logic [3:0] s, input logic [127:0] d,
                                input logic [31:0] ea, input logic [7:0] el,
                                input logic [2:0] es, input logic [3:0] est,
                                input int eb, input logic [127:0] ebv);
        vec_t v;
        v.typ = t; v.addr = a; v.strb = s; v.data = d;
        v.e_awaddr = ea; v.e_len = el; v.e_size = es; v.e_strb = est;
        v.e_beats = eb; v.e_beat = ebv;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [2:0] t, input logic [31:0] a,
                             input logic [3:0] s, input logic [127:0] d);
        bus.wr_req   = 1'b1;
        bus.wr_type  = t;
        bus.wr_addr  = a;
        bus.wr_wstrb = s;
        bus.wr_data  = d;
    endtask

    // One transaction with awready, wready and bvalid held high; checks exact
    // cycle alignment of every phase.
    task automatic run_txn(input int idx, input vec_t v);
        logic [31:0] exp_beat;
        drive_req(v.typ, v.addr, v.strb, v.data);
        bus.awready = 1'b1; bus.wready = 1'b1; bus.bvalid = 1'b1; bus.bresp = 2'b00;
        @(negedge clk);
        chk($sformatf("v%0d_accept_rdy", idx), bus.wr_rdy, 1'b1);
        tick();
        bus.wr_req = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_awvalid", idx), bus.awvalid, 1'b1);
        chk($sformatf("v%0d_awaddr", idx), bus.awaddr, v.e_awaddr);
        chk($sformatf("v%0d_awlen", idx), bus.awlen, v.e_len);
        chk($sformatf("v%0d_awsize", idx), bus.awsize, v.e_size);
        chk($sformatf("v%0d_awburst", idx), bus.awburst, 2'b01);
        chk($sformatf("v%0d_awid", idx), bus.awid, 4'd1);
        chk($sformatf("v%0d_wvalid_in_aw", idx), bus.wvalid, 1'b0);
        chk($sformatf("v%0d_busy_rdy", idx), bus.wr_rdy, 1'b0);
        tick();
        for (int i = 0; i < v.e_beats; i++) begin
            exp_beat = v.e_beat[32*i +: 32];
            @(negedge clk);
            chk($sformatf("v%0d_wvalid%0d", idx, i), bus.wvalid, 1'b1);
            chk($sformatf("v%0d_awvalid_in_w%0d", idx, i), bus.awvalid, 1'b0);
            chk($sformatf("v%0d_wdata%0d", idx, i), bus.wdata, exp_beat);
            chk($sformatf("v%0d_wstrb%0d", idx, i), bus.wstrb, v.e_strb);
            chk($sformatf("v%0d_wlast%0d", idx, i), bus.wlast, (i == v.e_beats - 1));
            tick();
        end
        @(negedge clk);
        chk($sformatf("v%0d_bready", idx), bus.bready, 1'b1);
        chk($sformatf("v%0d_wvalid_in_b", idx), bus.wvalid, 1'b0);
        chk($sformatf("v%0d_wr_err", idx), bus.wr_err, 1'b0);
        tick();
        @(negedge clk);
        chk($sformatf("v%0d_idle_rdy", idx), bus.wr_rdy, 1'b1);
        chk($sformatf("v%0d_idle_bready", idx), bus.bready, 1'b0);
        tick();
    endtask

    logic [127:0] bp_data;
    logic [31:0]  bp_beat;
    int           hs;

    initial begin
        vecs[0] = mk(3'b100, 32'h1C00_0124, 4'h0, 128'h44444444_33333333_22222222_11111111,
                     32'h1C00_0120, 8'd3, 3'd2, 4'hF, 4, 128'h44444444_33333333_22222222_11111111);
        vecs[1] = mk(3'b001, 32'hBFAF_8002, 4'b1100, 128'h99999999_88888888_77777777_ABCD0000,
                     32'hBFAF_8002, 8'd0, 3'd1, 4'b1100, 1, 128'h0000ABCD_0000);
        vecs[1].e_beat = 128'hABCD0000;
        vecs[2] = mk(3'b000, 32'h0000_1003, 4'b1000, 128'h5A000000,
                     32'h0000_1003, 8'd0, 3'd0, 4'b1000, 1, 128'h5A000000);
        vecs[3] = mk(3'b010, 32'h8000_0010, 4'hF, 128'h12345678,
                     32'h8000_0010, 8'd0, 3'd2, 4'hF, 1, 128'h12345678);
        vecs[4] = mk(3'b011, 32'h4000_0004, 4'b0011, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_0000BEEF,
                     32'h4000_0004, 8'd0, 3'd2, 4'b0011, 1, 128'h0000BEEF);
        vecs[5] = mk(3'b100, 32'h0000_000F, 4'h0, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA,
                     32'h0000_0000, 8'd3, 3'd2, 4'hF, 4, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
        vecs[6] = mk(3'b111, 32'h1234_5678, 4'b0001, 128'h000000A5,
                     32'h1234_5678, 8'd0, 3'd2, 4'b0001, 1, 128'h000000A5);

        reset = 1'b1;
        bus.wr_req = 1'b0; bus.wr_type = 3'b000; bus.wr_addr = 32'h0; bus.wr_wstrb = 4'h0;
        bus.wr_data = 128'h0; bus.chk_addr = 32'h0;
        bus.awready = 1'b0; bus.wready = 1'b0; bus.bid = 4'd0; bus.bresp = 2'b00; bus.bvalid = 1'b0;

        // Reset state
        tick();
        tick();
        @(negedge clk);
        chk("rst_wr_rdy", bus.wr_rdy, 1'b0);
        chk("rst_awvalid", bus.awvalid, 1'b0);
        chk("rst_wvalid", bus.wvalid, 1'b0);
        chk("rst_wlast", bus.wlast, 1'b0);
        chk("rst_bready", bus.bready, 1'b0);
        chk("rst_wr_err", bus.wr_err, 1'b0);
        chk("rst_chk_hit", bus.chk_hit, 1'b0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_wr_rdy", bus.wr_rdy, 1'b1);
        tick();

        // Table of single transactions
        for (int k = 0; k < 7; k++) begin
            run_txn(k, vecs[k]);
        end

        // Backpressure: awready low 3 cycles, wready toggling, bvalid late
        bp_data = 128'h89ABCDEF_01234567_FEDCBA98_76543210;
        drive_req(3'b100, 32'h2000_0048, 4'h0, bp_data);
        bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0;
        @(negedge clk);
        chk("bp_accept_rdy", bus.wr_rdy, 1'b1);
        tick();
        bus.wr_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("bp_aw_hold_valid%0d", c), bus.awvalid, 1'b1);
            chk($sformatf("bp_aw_hold_addr%0d", c), bus.awaddr, 32'h2000_0040);
            chk($sformatf("bp_aw_hold_len%0d", c), bus.awlen, 8'd3);
            chk($sformatf("bp_aw_hold_nowv%0d", c), bus.wvalid, 1'b0);
            tick();
        end
        bus.awready = 1'b1;
        @(negedge clk);
        chk("bp_aw_valid", bus.awvalid, 1'b1);
        chk("bp_aw_addr", bus.awaddr, 32'h2000_0040);
        tick();
        bus.awready = 1'b0;
        hs = 0;
        for (int c = 0; c < 20 && hs < 4; c++) begin
            bus.wready = (c % 2) == 1;
            bp_beat = bp_data[32*hs +: 32];
            @(negedge clk);
            chk($sformatf("bp_wvalid_c%0d", c), bus.wvalid, 1'b1);
            chk($sformatf("bp_wdata_c%0d", c), bus.wdata, bp_beat);
            chk($sformatf("bp_wlast_c%0d", c), bus.wlast, (hs == 3));
            if (bus.wready) hs++;
            tick();
        end
        bus.wready = 1'b0;
        chk("bp_w_handshakes", hs, 4);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk($sformatf("bp_b_wait_bready%0d", c), bus.bready, 1'b1);
            chk($sformatf("bp_b_wait_wvalid%0d", c), bus.wvalid, 1'b0);
            chk($sformatf("bp_b_wait_rdy%0d", c), bus.wr_rdy, 1'b0);
            tick();
        end
        bus.bvalid = 1'b1;
        @(negedge clk);
        chk("bp_b_bready", bus.bready, 1'b1);
        chk("bp_b_err", bus.wr_err, 1'b0);
        tick();
        bus.bvalid = 1'b0;
        @(negedge clk);
        chk("bp_idle_rdy", bus.wr_rdy, 1'b1);
        tick();

        // Conflict detection during a line write
        bus.chk_addr = 32'h1C00_012C;
        @(negedge clk);
        chk("cf_idle_hit", bus.chk_hit, 1'b0);
        tick();
        drive_req(3'b100, 32'h1C00_0124, 4'h0, 128'h44444444_33333333_22222222_11111111);
        bus.awready = 1'b1; bus.wready = 1'b1; bus.bvalid = 1'b1; bus.bresp = 2'b00;
        @(negedge clk);
        chk("cf_accept_hit", bus.chk_hit, 1'b0);
        tick();
        bus.wr_req = 1'b0;
        @(negedge clk);
        chk("cf_aw_hit_12c", bus.chk_hit, 1'b1);
        tick();
        bus.chk_addr = 32'h1C00_0130;
        @(negedge clk);
        chk("cf_w0_miss_130", bus.chk_hit, 1'b0);
        tick();
        bus.chk_addr = 32'h1C00_0120;
        @(negedge clk);
        chk("cf_w1_hit_120", bus.chk_hit, 1'b1);
        tick();
        bus.chk_addr = 32'h1C00_011C;
        @(negedge clk);
        chk("cf_w2_miss_11c", bus.chk_hit, 1'b0);
        tick();
        bus.chk_addr = 32'h1C00_012F;
        @(negedge clk);
        chk("cf_w3_hit_12f", bus.chk_hit, 1'b1);
        chk("cf_w3_wlast", bus.wlast, 1'b1);
        tick();
        bus.chk_addr = 32'h1C00_0124;
        @(negedge clk);
        chk("cf_b_hit", bus.chk_hit, 1'b1);
        chk("cf_b_bready", bus.bready, 1'b1);
        tick();
        @(negedge clk);
        chk("cf_idle_after_hit", bus.chk_hit, 1'b0);
        chk("cf_idle_rdy", bus.wr_rdy, 1'b1);
        tick();

        // Error response on an uncached word store
        drive_req(3'b010, 32'hBFAF_8004, 4'hF, 128'hCAFEF00D);
        bus.awready = 1'b1; bus.wready = 1'b1; bus.bvalid = 1'b0; bus.bresp = 2'b10;
        bus.chk_addr = 32'hBFAF_800C;
        @(negedge clk);
        chk("er_accept_rdy", bus.wr_rdy, 1'b1);
        tick();
        bus.wr_req = 1'b0;
        @(negedge clk);
        chk("er_aw_valid", bus.awvalid, 1'b1);
        chk("er_uc_hit", bus.chk_hit, 1'b1);
        tick();
        @(negedge clk);
        chk("er_w_data", bus.wdata, 32'hCAFEF00D);
        chk("er_w_last", bus.wlast, 1'b1);
        tick();
        @(negedge clk);
        chk("er_b_wait_bready", bus.bready, 1'b1);
        chk("er_b_wait_err", bus.wr_err, 1'b0);
        tick();
        bus.bvalid = 1'b1;
        @(negedge clk);
        chk("er_pulse", bus.wr_err, 1'b1);
        tick();
        bus.bvalid = 1'b0; bus.bresp = 2'b00;
        @(negedge clk);
        chk("er_pulse_end", bus.wr_err, 1'b0);
        chk("er_idle_rdy", bus.wr_rdy, 1'b1);
        chk("er_idle_bready", bus.bready, 1'b0);
        tick();

        // Reset in the middle of a line burst, after two beats
        drive_req(3'b100, 32'h3000_0010, 4'h0, 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A);
        bus.awready = 1'b1; bus.wready = 1'b1; bus.bvalid = 1'b0;
        bus.chk_addr = 32'h3000_0014;
        tick();
        bus.wr_req = 1'b0;
        tick();
        tick();
        tick();
        @(negedge clk);
        chk("mr_w2_valid", bus.wvalid, 1'b1);
        chk("mr_w2_data", bus.wdata, 32'h0C0C0C0C);
        reset = 1'b1;
        tick();
        @(negedge clk);
        chk("mr_awvalid", bus.awvalid, 1'b0);
        chk("mr_wvalid", bus.wvalid, 1'b0);
        chk("mr_bready", bus.bready, 1'b0);
        chk("mr_wlast", bus.wlast, 1'b0);
        chk("mr_chk_hit", bus.chk_hit, 1'b0);
        chk("mr_rdy_in_reset", bus.wr_rdy, 1'b0);
        reset = 1'b0;
        tick();
        run_txn(7, vecs[5]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
